// File: rtl/hb_up2_mc.sv
// hb_up2_mc: time-multiplexed multi-channel half-band interpolate-by-2 filter.
// Each accepted sample yields a {center, filtered-midpoint} pair five cycles later.
module hb_up2_mc #(
  parameter int XIN_WIDTH      = 16,
  parameter int COE_WIDTH      = 16,
  parameter int NUM_UNIQUE_COE = 3,
  parameter logic signed [COE_WIDTH-1:0] COE_NUMS [NUM_UNIQUE_COE] =
    '{COE_WIDTH'(1277), COE_WIDTH'(-4710), COE_WIDTH'(20014)},
  parameter int YOUT_WIDTH     = 16,
  parameter int SRA_BITS       = 15,
  parameter int NUM_CH         = 4,
  parameter int ROUND_MODE     = 1,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [XIN_WIDTH-1:0]  xin,
  input  logic                         xin_valid,
  input  logic                         xin_first,
  output logic signed [YOUT_WIDTH-1:0] yout0,
  output logic signed [YOUT_WIDTH-1:0] yout1,
  output logic                         yout_valid,
  output logic [CH_W-1:0]              yout_ch,
  output logic                         ovf,
  output logic                         ovf_sticky,
  input  logic                         ovf_clr
);

  localparam int K      = NUM_UNIQUE_COE;
  localparam int NTAP   = 2 * K;
  localparam int PRE_W  = XIN_WIDTH + 1;
  localparam int PROD_W = PRE_W + COE_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(K);
  localparam int RND_W  = SUM_W + 1;
  localparam logic signed [RND_W-1:0] RND_C =
    (ROUND_MODE != 0) ? RND_W'((64'd1 << SRA_BITS) >> 1) : '0;
  localparam logic signed [RND_W-1:0] Y_MAX = {{(RND_W-YOUT_WIDTH+1){1'b0}}, {(YOUT_WIDTH-1){1'b1}}};
  localparam logic signed [RND_W-1:0] Y_MIN = {{(RND_W-YOUT_WIDTH+1){1'b1}}, {(YOUT_WIDTH-1){1'b0}}};

  logic [CH_W-1:0]              r_ch, w_ch;
  logic [CH_W-1:0]              r0_ch, r1_ch, r2_ch, r3_ch, r4_ch;
  logic                         r0_v, r1_v, r2_v, r3_v, r4_v;
  logic signed [XIN_WIDTH-1:0]  r_hist [NUM_CH][NTAP-1];
  logic signed [XIN_WIDTH-1:0]  r0_d [NTAP];
  logic signed [XIN_WIDTH-1:0]  r1_ctr, r2_ctr, r3_ctr;
  logic signed [PRE_W-1:0]      w_pre [K];
  logic signed [PRE_W-1:0]      r1_pre [K];
  logic signed [PROD_W-1:0]     w_prod [K];
  logic signed [PROD_W-1:0]     r2_prod [K];
  logic signed [SUM_W-1:0]      w_sum, r3_sum;
  logic signed [RND_W-1:0]      w_rnd, w_shr;
  logic signed [YOUT_WIDTH-1:0] w_y0, w_y1, r4_y0, r4_y1;
  logic                         w_ovf, r4_ovf;

  // xin_first forces channel 0 and the counter resumes from there
  assign w_ch = xin_first ? '0 : r_ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch <= '0;
    end else if (xin_valid) begin
      r_ch <= (w_ch == CH_W'(NUM_CH - 1)) ? '0 : w_ch + CH_W'(1);
    end
  end

  // S0: tap vector from the channel history; history written back the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int j = 0; j < NTAP - 1; j++) r_hist[c][j] <= '0;
      for (int j = 0; j < NTAP; j++) r0_d[j] <= '0;
      r0_v  <= 1'b0;
      r0_ch <= '0;
    end else begin
      r0_v    <= xin_valid;
      r0_ch   <= w_ch;
      r0_d[0] <= xin;
      for (int j = 1; j < NTAP; j++) r0_d[j] <= r_hist[w_ch][j-1];
      if (xin_valid) begin
        r_hist[w_ch][0] <= xin;
        for (int j = 1; j < NTAP - 1; j++) r_hist[w_ch][j] <= r_hist[w_ch][j-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_tap
      assign w_pre[gi]  = PRE_W'(r0_d[gi]) + PRE_W'(r0_d[NTAP-1-gi]);
      assign w_prod[gi] = PROD_W'(r1_pre[gi]) * PROD_W'(COE_NUMS[gi]);
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < K; k++) w_sum = w_sum + SUM_W'(r2_prod[k]);
  end

  always_comb begin
    w_rnd = RND_W'(r3_sum) + RND_C;
    w_shr = w_rnd >>> SRA_BITS;
    w_y1  = w_shr[YOUT_WIDTH-1:0];
    w_ovf = 1'b0;
    if (w_shr > Y_MAX) begin
      w_y1  = Y_MAX[YOUT_WIDTH-1:0];
      w_ovf = 1'b1;
    end else if (w_shr < Y_MIN) begin
      w_y1  = Y_MIN[YOUT_WIDTH-1:0];
      w_ovf = 1'b1;
    end
    w_y0 = YOUT_WIDTH'(r3_ctr) <<< (YOUT_WIDTH - XIN_WIDTH);
  end

  // S1 pre-add, S2 multiply, S3 sum, S4 round/saturate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < K; k++) begin
        r1_pre[k]  <= '0;
        r2_prod[k] <= '0;
      end
      {r1_v, r2_v, r3_v, r4_v}     <= '0;
      {r1_ch, r2_ch, r3_ch, r4_ch} <= '0;
      {r1_ctr, r2_ctr, r3_ctr}     <= '0;
      r3_sum <= '0;
      r4_y0  <= '0;
      r4_y1  <= '0;
      r4_ovf <= 1'b0;
    end else begin
      for (int k = 0; k < K; k++) begin
        r1_pre[k]  <= w_pre[k];
        r2_prod[k] <= w_prod[k];
      end
      {r1_v, r2_v, r3_v, r4_v}     <= {r0_v, r1_v, r2_v, r3_v};
      {r1_ch, r2_ch, r3_ch, r4_ch} <= {r0_ch, r1_ch, r2_ch, r3_ch};
      {r1_ctr, r2_ctr, r3_ctr}     <= {r0_d[K], r1_ctr, r2_ctr};
      r3_sum <= w_sum;
      r4_y0  <= w_y0;
      r4_y1  <= w_y1;
      r4_ovf <= w_ovf;
    end
  end

  // Output register holds its value between pairs; a new overflow beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yout0      <= '0;
      yout1      <= '0;
      yout_valid <= 1'b0;
      yout_ch    <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      yout_valid <= r4_v;
      if (r4_v) begin
        yout0   <= r4_y0;
        yout1   <= r4_y1;
        yout_ch <= r4_ch;
        ovf     <= r4_ovf;
      end
      if (r4_v && r4_ovf) ovf_sticky <= 1'b1;
      else if (ovf_clr)   ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hb_up2_mc.sv
// Bench for hb_up2_mc: three instances (1ch round, 1ch floor, 4ch round) share one
// stimulus bus; a direct-form FIR model feeds per-instance scoreboards.
module tb_hb_up2_mc;

  typedef struct {
    int y0;
    int y1;
    int ch;
    int ovf;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] xin = '0;
  logic xin_valid = 1'b0, xin_first = 1'b0, ovf_clr = 1'b0;

  logic signed [15:0] y0_a, y1_a, y0_b, y1_b, y0_c, y1_c;
  logic vld_a, vld_b, vld_c, ov_a, ov_b, ov_c, st_a, st_b, st_c;
  logic [0:0] ch_a, ch_b;
  logic [1:0] ch_c;

  hb_up2_mc #(.NUM_CH(1), .ROUND_MODE(1)) u_dut_a (
    .clk(clk), .rst(rst), .xin(xin), .xin_valid(xin_valid), .xin_first(xin_first),
    .yout0(y0_a), .yout1(y1_a), .yout_valid(vld_a), .yout_ch(ch_a),
    .ovf(ov_a), .ovf_sticky(st_a), .ovf_clr(ovf_clr));

  hb_up2_mc #(.NUM_CH(1), .ROUND_MODE(0)) u_dut_b (
    .clk(clk), .rst(rst), .xin(xin), .xin_valid(xin_valid), .xin_first(xin_first),
    .yout0(y0_b), .yout1(y1_b), .yout_valid(vld_b), .yout_ch(ch_b),
    .ovf(ov_b), .ovf_sticky(st_b), .ovf_clr(ovf_clr));

  hb_up2_mc #(.NUM_CH(4), .ROUND_MODE(1)) u_dut_c (
    .clk(clk), .rst(rst), .xin(xin), .xin_valid(xin_valid), .xin_first(xin_first),
    .yout0(y0_c), .yout1(y1_c), .yout_valid(vld_c), .yout_ch(ch_c),
    .ovf(ov_c), .ovf_sticky(st_c), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  int   edge_n = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q  [3][$];
  exp_t lg [3][$];
  int   hist [3][4][6];
  int   ch_m [3];
  bit   sticky_m [3];
  bit   clr_prev [3];
  int   last_y0 [3], last_y1 [3], last_ch [3], last_ov [3];
  int   coe_full [6] = '{1277, -4710, 20014, 20014, -4710, 1277};
  int   imp_r1 [7]   = '{639, -2355, 10007, 10007, -2355, 639, 0};
  int   imp_r0 [6]   = '{638, -2355, 10007, 10007, -2355, 638};

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic int rand16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // Reference: direct-form 4K-1 tap FIR odd phase on a per-channel sample history
  function automatic void model_accept(int idx, bit first, int x);
    int nch, c;
    longint s;
    exp_t e;
    nch = (idx == 2) ? 4 : 1;
    c = first ? 0 : ch_m[idx];
    ch_m[idx] = (c + 1) % nch;
    for (int j = 5; j > 0; j--) hist[idx][c][j] = hist[idx][c][j-1];
    hist[idx][c][0] = x;
    s = 0;
    for (int j = 0; j < 6; j++) s += longint'(coe_full[j]) * longint'(hist[idx][c][j]);
    if (idx != 1) s += 16384;
    s = s >>> 15;
    e.ovf = 0;
    if (s > 32767) begin s = 32767; e.ovf = 1; end
    else if (s < -32768) begin s = -32768; e.ovf = 1; end
    e.y1  = int'(s);
    e.y0  = hist[idx][c][3];
    e.ch  = c;
    e.due = edge_n + 6;
    q[idx].push_back(e);
  endfunction

  function automatic void mon(int idx, logic v, int y0, int y1, int ch, logic ov, logic stk);
    exp_t e, a;
    bit set;
    set = 1'b0;
    if (v) begin
      if (q[idx].size() == 0) begin
        chk($sformatf("spurious_valid[%0d]", idx), 1, 0);
      end else begin
        e = q[idx].pop_front();
        chk($sformatf("yout0[%0d]", idx), y0, e.y0);
        chk($sformatf("yout1[%0d]", idx), y1, e.y1);
        chk($sformatf("yout_ch[%0d]", idx), ch, e.ch);
        chk($sformatf("ovf[%0d]", idx), int'(ov), e.ovf);
        chk($sformatf("latency_edge[%0d]", idx), edge_n, e.due);
        set = (e.ovf != 0);
      end
      $display("pair inst=%0d ch=%0d y0=%0d y1=%0d ovf=%0d", idx, ch, y0, y1, ov);
      a.y0 = y0; a.y1 = y1; a.ch = ch; a.ovf = int'(ov); a.due = edge_n;
      lg[idx].push_back(a);
      last_y0[idx] = y0; last_y1[idx] = y1; last_ch[idx] = ch; last_ov[idx] = int'(ov);
    end else begin
      if (q[idx].size() > 0 && q[idx][0].due <= edge_n) begin
        chk($sformatf("missing_valid[%0d]", idx), 0, 1);
        void'(q[idx].pop_front());
      end
      chk($sformatf("hold_y1[%0d]", idx), y1, last_y1[idx]);
      chk($sformatf("hold_other[%0d]", idx),
          (y0 == last_y0[idx] && ch == last_ch[idx] && int'(ov) == last_ov[idx]) ? 1 : 0, 1);
    end
    if (set) sticky_m[idx] = 1'b1;
    else if (clr_prev[idx]) sticky_m[idx] = 1'b0;
    chk($sformatf("ovf_sticky[%0d]", idx), int'(stk), int'(sticky_m[idx]));
    clr_prev[idx] = ovf_clr;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, vld_a, int'(y0_a), int'(y1_a), int'(ch_a), ov_a, st_a);
      mon(1, vld_b, int'(y0_b), int'(y1_b), int'(ch_b), ov_b, st_b);
      mon(2, vld_c, int'(y0_c), int'(y1_c), int'(ch_c), ov_c, st_c);
    end
  end

  task automatic drive(bit v, bit f, int x, bit clr);
    @(posedge clk);
    #1;
    xin_valid = v;
    xin_first = f;
    xin       = 16'(x);
    ovf_clr   = clr;
    if (v) for (int i = 0; i < 3; i++) model_accept(i, f, x);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, rand16(), 1'b0);
  endtask

  task automatic do_reset(int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    xin_valid = 1'b0; xin_first = 1'b0; ovf_clr = 1'b0; xin = '0;
    #1;
    chk("rst_yout0_a", int'(y0_a), 0);
    chk("rst_yout1_a", int'(y1_a), 0);
    chk("rst_yout0_c", int'(y0_c), 0);
    chk("rst_yout1_c", int'(y1_c), 0);
    chk("rst_valid_ch_c", int'(vld_c) + int'(ch_c), 0);
    chk("rst_ovf_flags", int'(ov_a) + int'(st_a) + int'(ov_c) + int'(st_c), 0);
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      lg[i].delete();
      ch_m[i] = 0; sticky_m[i] = 1'b0; clr_prev[i] = 1'b0;
      last_y0[i] = 0; last_y1[i] = 0; last_ch[i] = 0; last_ov[i] = 0;
      for (int c = 0; c < 4; c++) for (int j = 0; j < 6; j++) hist[i][c][j] = 0;
    end
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic impulse_test();
    for (int i = 0; i < 3; i++) lg[i].delete();
    drive(1'b1, 1'b1, 16384, 1'b0);
    repeat (7) drive(1'b1, 1'b0, 0, 1'b0);
    idle(8);
    chk("imp_pairs_a", lg[0].size(), 8);
    chk("imp_pairs_b", lg[1].size(), 8);
    if (lg[0].size() >= 7) begin
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("imp_y1_round[%0d]", i), lg[0][i].y1, imp_r1[i]);
        chk($sformatf("imp_y0[%0d]", i), lg[0][i].y0, (i == 3) ? 16384 : 0);
      end
    end
    if (lg[1].size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("imp_y1_floor[%0d]", i), lg[1][i].y1, imp_r0[i]);
  endtask

  initial begin
    int   rs [40];
    exp_t la [$];

    do_reset(3);

    // impulse on single-channel instances
    impulse_test();

    // saturation and sticky flag behaviour
    repeat (10) drive(1'b1, 1'b0, 32767, 1'b0);
    drive(1'b1, 1'b0, 32767, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 32767, 1'b0);
    @(negedge clk);
    chk("sat_pos_y1", int'(y1_a), 32767);
    chk("sat_pos_ovf", int'(ov_a), 1);
    chk("sat_sticky_after_clr", int'(st_a), 1);
    repeat (14) drive(1'b1, 1'b0, -32768, 1'b0);
    @(negedge clk);
    chk("sat_neg_y1", int'(y1_a), -32768);
    chk("sat_neg_ovf", int'(ov_a), 1);
    repeat (10) drive(1'b1, 1'b0, 0, 1'b0);
    idle(8);
    @(negedge clk);
    chk("sticky_before_clr", int'(st_a), 1);
    drive(1'b0, 1'b0, 0, 1'b1);
    idle(2);
    @(negedge clk);
    chk("sticky_cleared", int'(st_a), 0);

    // channel isolation: impulse on channel 2 only
    do_reset(3);
    for (int f = 0; f < 6; f++)
      for (int c = 0; c < 4; c++)
        drive(1'b1, c == 0, (f == 0 && c == 2) ? 16384 : 0, 1'b0);
    idle(8);
    chk("iso_pairs", lg[2].size(), 24);
    if (lg[2].size() >= 24) begin
      for (int i = 0; i < 24; i++) begin
        chk($sformatf("iso_ch[%0d]", i), lg[2][i].ch, i % 4);
        chk($sformatf("iso_y0[%0d]", i), lg[2][i].y0, (i % 4 == 2 && i / 4 == 3) ? 16384 : 0);
        chk($sformatf("iso_y1[%0d]", i), lg[2][i].y1, (i % 4 == 2) ? imp_r1[i / 4] : 0);
      end
    end

    // random 4-channel stream, gapless then replayed with gaps
    do_reset(3);
    for (int i = 0; i < 40; i++) begin
      rs[i] = rand16();
      drive(1'b1, (i % 4) == 0, rs[i], 1'b0);
    end
    idle(8);
    la = lg[2];
    do_reset(3);
    for (int i = 0; i < 40; i++) begin
      while ($urandom_range(0, 99) < 40) drive(1'b0, 1'b0, rand16(), 1'b0);
      drive(1'b1, (i % 4) == 0, rs[i], 1'b0);
    end
    idle(8);
    chk("gap_pairs", lg[2].size(), la.size());
    if (lg[2].size() == la.size()) begin
      for (int i = 0; i < la.size(); i++) begin
        chk($sformatf("gap_y1[%0d]", i), lg[2][i].y1, la[i].y1);
        chk($sformatf("gap_y0_ch[%0d]", i),
            (lg[2][i].y0 == la[i].y0 && lg[2][i].ch == la[i].ch) ? 1 : 0, 1);
      end
    end

    // reset mid-stream, then the impulse must reproduce exactly
    for (int i = 0; i < 10; i++) drive(1'b1, (i % 4) == 0, rand16(), 1'b0);
    do_reset(3);
    idle(10);
    impulse_test();

    // resync: xin_first on the third sample of a frame
    do_reset(3);
    drive(1'b1, 1'b1, rand16(), 1'b0);
    drive(1'b1, 1'b0, rand16(), 1'b0);
    drive(1'b1, 1'b1, rand16(), 1'b0);
    drive(1'b1, 1'b0, rand16(), 1'b0);
    drive(1'b1, 1'b0, rand16(), 1'b0);
    idle(8);
    chk("resync_pairs", lg[2].size(), 5);
    if (lg[2].size() >= 5) begin
      chk("resync_ch2", lg[2][2].ch, 0);
      chk("resync_ch3", lg[2][3].ch, 1);
      chk("resync_ch4", lg[2][4].ch, 2);
    end

    idle(4);
    for (int i = 0; i < 3; i++) chk($sformatf("queue_drained[%0d]", i), q[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
